alu: RTL and testbench

Sequential arithmetic/logic unit directly downstream of the register file. It consumes the two register read ports as operands A and B and returns a registered result that the control path writes back through the register file's data input. Most operations complete in one cycle. MUL runs as an iterative shift-add over DATA_BUS_WIDTH cycles, and a start/busy/done handshake tells the controller when the result is valid.

---
 rtl/alu.sv | 179 +++++++++++++++++
 tb/tb_alu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Sequential ALU between the register-file read ports and its write-back input.
// Latency: 1 cycle for ADD/SUB/logic/shift, DATA_BUS_WIDTH+1 cycles to done for MUL.
// Backpressure: none; start is taken only while idle, and is dropped (not queued) while busy or done.
//
// Ports:
//   clock, reset  - system clock; asynchronous active-low reset
//   start, op     - request strobe and operation code (0 ADD .. 7 MUL)
//   a, b          - operands from register read ports 1 and 2
//   result, flags - registered result and {N,V,C,Z}; hold until the next completion
//   busy, done    - busy while MUL iterates; done pulses one cycle per completion
module alu #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [DATA_BUS_WIDTH-1:0] a,
  input  logic [DATA_BUS_WIDTH-1:0] b,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [3:0]                flags,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } flags_t;

  state_t         state, state_nxt;
  flags_t         flags_q;
  logic [W-1:0]   result_q;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           load_alu, load_mul, mul_step, mul_fin;

  // Single-cycle datapath
  logic [W:0]     sum, diff;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];  // borrow: set when a < b unsigned
        alu_v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[W-2:0], 1'b0};
        alu_c   = a[W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[W-1:1]};
        alu_c   = a[0];
      end
      default: ;
    endcase
  end

  // Accumulator value after the current shift-add step; also the final
  // product when the last iteration is taken.
  logic [2*W-1:0] acc_step;
  logic           mul_last;

  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(W - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state and datapath controls
  always_comb begin
    state_nxt = state;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_step  = 1'b0;
    mul_fin   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            load_mul  = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            load_alu  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          mul_fin   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; result/flags only move on the edge entering DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      if (load_alu) begin
        result_q <= alu_res;
        flags_q  <= '{n: alu_res[W-1], v: alu_v, c: alu_c, z: (alu_res == '0)};
      end
      if (load_mul) begin
        mcand  <= {{W{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      if (mul_step) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (mul_fin) begin
        result_q <= acc_step[W-1:0];
        flags_q  <= '{n: acc_step[W-1], v: 1'b0, c: (acc_step[2*W-1:W] != '0),
                      z: (acc_step[W-1:0] == '0)};
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = (state == ST_MUL);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu (W=8): vector table for single-cycle ops, plus
// hand-written MUL timing, mid-MUL disturbance, reset abort and back-to-back.
module tb_alu;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;

  alu #(.DATA_BUS_WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags = {N, V, C, Z}
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] er, input logic [3:0] ef, input string nm);
    @(negedge clock);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clock); #1;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " result"}, 32'(result), 32'(er));
    chk({nm, " flags"}, 32'(flags), 32'(ef));
    start = 1'b0;
    @(posedge clock); #1;
    chk({nm, " done drop"}, 32'(done), 32'd0);
    chk({nm, " result hold"}, 32'(result), 32'(er));
  endtask

  task automatic mul_run(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] er,
                         input logic [3:0] ef, input bit disturb, input string nm);
    int busy_cnt;
    int done_at;
    logic [7:0] prev;
    busy_cnt = 0;
    done_at  = 0;
    prev     = result;
    @(negedge clock);
    start = 1'b1; op = 3'd7; a = aa; b = bb;
    @(posedge clock); #1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin
        @(posedge clock); #1;
      end
      if (busy && done) chk({nm, " busy&done"}, 32'd1, 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = i;
        chk({nm, " result"}, 32'(result), 32'(er));
        chk({nm, " flags"}, 32'(flags), 32'(ef));
        break;
      end
      if (i == 4) chk({nm, " result hold mid"}, 32'(result), 32'(prev));
      if (disturb) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 7));
        a     = 8'($urandom);
        b     = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'd8);
    chk({nm, " done cycle"}, 32'(done_at), 32'd9);
    @(posedge clock); #1;
    chk({nm, " done drop"}, 32'(done), 32'd0);
    @(posedge clock); #1;
    chk({nm, " no extra done"}, 32'(done), 32'd0);
    chk({nm, " result stable"}, 32'(result), 32'(er));
  endtask

  initial begin
    int dones;
    bit sel;
    logic [7:0] er;
    logic [3:0] ef;

    vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[1]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[2]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010};
    vecs[3]  = '{3'd2, 8'hF0, 8'h0F, 8'h00, 4'b0001};
    vecs[4]  = '{3'd5, 8'h81, 8'h55, 8'h02, 4'b0010};
    vecs[5]  = '{3'd6, 8'h01, 8'hAA, 8'h00, 4'b0011};
    vecs[6]  = '{3'd3, 8'hA0, 8'h05, 8'hA5, 4'b1000};
    vecs[7]  = '{3'd4, 8'h55, 8'hFF, 8'hAA, 4'b1000};
    vecs[8]  = '{3'd1, 8'h05, 8'h03, 8'h02, 4'b0000};
    vecs[9]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0100};
    vecs[10] = '{3'd0, 8'h80, 8'h80, 8'h00, 4'b0111};

    reset = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    #1;
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg,
            $sformatf("vec%0d", i));

    mul_run(8'h0C, 8'h0B, 8'h84, 4'b1000, 1'b0, "mul 0C*0B");
    mul_run(8'h10, 8'h10, 8'h00, 4'b0011, 1'b1, "mul 10*10 disturbed");
    mul_run(8'h0C, 8'h0B, 8'h84, 4'b1000, 1'b0, "mul after disturb");

    // Reset in the middle of a MUL: immediate clear, no done afterwards.
    @(negedge clock);
    start = 1'b1; op = 3'd7; a = 8'h0F; b = 8'h0F;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("abort busy before reset", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort result", 32'(result), 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done || busy) dones++;
    end
    chk("abort no done/busy", 32'(dones), 32'd0);
    do_op(3'd0, 8'h01, 8'h02, 8'h03, 4'b0000, "add after abort");

    // Back-to-back: start held high, alternating ADD (01+02) and XOR (3C^3C).
    sel = 1'b0;
    er  = result;
    ef  = flags;
    @(negedge clock);
    start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h02;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      chk($sformatf("b2b done c%0d", i), 32'(done), 32'(i % 2));
      if (i % 2 == 1) begin
        er = sel ? 8'h00 : 8'h03;
        ef = sel ? 4'b0001 : 4'b0000;
        sel = ~sel;
        if (sel) begin op = 3'd4; a = 8'h3C; b = 8'h3C; end
        else     begin op = 3'd0; a = 8'h01; b = 8'h02; end
      end
      chk($sformatf("b2b result c%0d", i), 32'(result), 32'(er));
      chk($sformatf("b2b flags c%0d", i), 32'(flags), 32'(ef));
    end
    start = 1'b0;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
